// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, lane steering, load extension
// and a bounded wait for mem_ack. All outputs come from registers.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_n;
    logic [7:0]            cnt, cnt_n;
    logic [2:0]            funct3_q, funct3_n;
    logic [1:0]            off_q, off_n;
    logic                  store_q, store_n;
    logic                  resp_valid_n, resp_err_n, mem_req_n, mem_we_n;
    logic [DATA_WIDTH-1:0] resp_rdata_n, mem_addr_n, mem_wdata_n;
    logic [3:0]            mem_be_n;

    logic                  legal, misaligned;
    logic [3:0]            be_req;
    logic [DATA_WIDTH-1:0] wdata_req, load_data;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Request decode straight from the core-side inputs
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_req     = 4'b1111;
        wdata_req  = '0;
        if (req_store)
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    be_req    = 4'b0001 << req_addr[1:0];
                    wdata_req = {(DATA_WIDTH/8){req_wdata[7:0]}};
                end
                2'b01: begin
                    be_req    = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_req = {(DATA_WIDTH/16){req_wdata[15:0]}};
                end
                default: begin
                    be_req    = 4'b1111;
                    wdata_req = req_wdata;
                end
            endcase
        end
    end

    // Load extraction uses the offset and size captured at accept
    always_comb begin
        byte_sel  = mem_rdata[{off_q, 3'b000} +: 8];
        half_sel  = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        funct3_n     = funct3_q;
        off_n        = off_q;
        store_n      = store_q;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        mem_req_n    = mem_req;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_be_n     = mem_be;
        mem_wdata_n  = mem_wdata;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (req_valid) begin
                    funct3_n = req_funct3;
                    off_n    = req_addr[1:0];
                    store_n  = req_store;
                    if (!legal || misaligned) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else begin
                        state_n     = ACCESS;
                        mem_req_n   = 1'b1;
                        mem_we_n    = req_store;
                        mem_addr_n  = {req_addr[DATA_WIDTH-1:2], 2'b00};
                        mem_be_n    = be_req;
                        mem_wdata_n = wdata_req;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_n      = RESP;
                    mem_req_n    = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = store_q ? '0 : load_data;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state_n      = RESP;
                    mem_req_n    = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            store_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            funct3_q   <= funct3_n;
            off_q      <= off_n;
            store_q    <= store_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_be     <= mem_be_n;
            mem_wdata  <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; inputs change and outputs are sampled 1ns after rising edges.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        busy, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        step(); step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
        checks++; if ({resp_valid, resp_err, busy, mem_req, mem_we} !== 5'b0) begin failures++; $display("FAIL rst_ctrl: got %b expected 00000", {resp_valid, resp_err, busy, mem_req, mem_we}); end
        checks++; if ({resp_rdata, mem_addr, mem_wdata, mem_be} !== 100'b0) begin failures++; $display("FAIL rst_data: got %h/%h/%h/%h expected zeros", resp_rdata, mem_addr, mem_wdata, mem_be); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_lb();
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        checks++; if ({busy, mem_req, mem_we} !== 3'b110) begin failures++; $display("FAIL lb_c1: got busy/req/we %b expected 110", {busy, mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL lb_addr: got %h expected 00000100", mem_addr); end
        checks++; if (mem_be !== 4'b1111) begin failures++; $display("FAIL lb_be: got %b expected 1111", mem_be); end
        step();
        checks++; if ({busy, mem_req} !== 2'b11) begin failures++; $display("FAIL lb_c2: got %b expected 11", {busy, mem_req}); end
        step();
        checks++; if ({busy, mem_req, mem_addr} !== {2'b11, 32'h100}) begin failures++; $display("FAIL lb_c3: got %b %h expected 11 00000100", {busy, mem_req}, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        step();
        mem_ack = 1'b0;
        checks++; if ({busy, mem_req, resp_valid, resp_err} !== 4'b1010) begin failures++; $display("FAIL lb_resp_ctrl: got %b expected 1010", {busy, mem_req, resp_valid, resp_err}); end
        checks++; if (resp_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata: got %h expected ffffff80", resp_rdata); end
        step();
        checks++; if ({busy, resp_valid, req_ready} !== 3'b001) begin failures++; $display("FAIL lb_idle: got %b expected 001", {busy, resp_valid, req_ready}); end
    endtask

    task automatic test_sh();
        issue(1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
        checks++; if ({mem_req, mem_we, mem_be} !== 6'b111100) begin failures++; $display("FAIL sh_ctrl: got req/we/be %b expected 111100", {mem_req, mem_we, mem_be}); end
        checks++; if (mem_wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_wdata: got %h expected abcdabcd", mem_wdata); end
        checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL sh_addr: got %h expected 00000200", mem_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL sh_resp: got %b %h expected 10 00000000", {resp_valid, resp_err}, resp_rdata); end
        step();
        checks++; if ({resp_valid, mem_req} !== 2'b00) begin failures++; $display("FAIL sh_after: got %b expected 00", {resp_valid, mem_req}); end
    endtask

    task automatic test_sb_lh();
        issue(1'b1, 3'b000, 32'h7, 32'h1234_5678);
        checks++; if ({mem_be, mem_addr, mem_wdata} !== {4'b1000, 32'h4, 32'h7878_7878}) begin failures++; $display("FAIL sb_lanes: got %b %h %h expected 1000 00000004 78787878", mem_be, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        issue(1'b0, 3'b001, 32'h2, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h8001_0000;
        step();
        mem_ack = 1'b0;
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'hFFFF_8001}) begin failures++; $display("FAIL lh_sext: got %b %h expected 10 ffff8001", {resp_valid, resp_err}, resp_rdata); end
        step();
    endtask

    task automatic test_errors();
        issue(1'b0, 3'b010, 32'h005, 32'h0);
        checks++; if ({mem_req, resp_valid, resp_err, resp_rdata} !== {3'b011, 32'h0}) begin failures++; $display("FAIL lw_misalign: got %b %h expected 011 00000000", {mem_req, resp_valid, resp_err}, resp_rdata); end
        step();
        checks++; if ({resp_valid, busy, req_ready} !== 3'b001) begin failures++; $display("FAIL misalign_idle: got %b expected 001", {resp_valid, busy, req_ready}); end
        issue(1'b0, 3'b011, 32'h0, 32'h0);
        checks++; if ({mem_req, resp_valid, resp_err, resp_rdata} !== {3'b011, 32'h0}) begin failures++; $display("FAIL ld_illegal: got %b %h expected 011 00000000", {mem_req, resp_valid, resp_err}, resp_rdata); end
        step();
        issue(1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF);
        checks++; if ({mem_req, resp_valid, resp_err} !== 3'b011) begin failures++; $display("FAIL st_illegal: got %b expected 011", {mem_req, resp_valid, resp_err}); end
        step();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        issue(1'b0, 3'b101, 32'h2, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (!mem_req) break;
            req_cycles++;
            step();
        end
        checks++; if (req_cycles !== 4) begin failures++; $display("FAIL to_req_cycles: got %0d expected 4", req_cycles); end
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h0}) begin failures++; $display("FAIL to_resp: got %b %h expected 11 00000000", {resp_valid, resp_err}, resp_rdata); end
        step();
    endtask

    task automatic test_reset_mid_access();
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rma_req: got %b expected 1", mem_req); end
        #2;
        rst = 1'b0; mem_ack = 1'b1;
        #1;
        checks++; if ({mem_req, busy, req_ready, resp_valid} !== 4'b0010) begin failures++; $display("FAIL rma_async: got %b expected 0010", {mem_req, busy, req_ready, resp_valid}); end
        step(); step();
        checks++; if ({mem_req, resp_valid} !== 2'b00) begin failures++; $display("FAIL rma_noresp: got %b expected 00", {mem_req, resp_valid}); end
        mem_ack = 1'b0;
        #2;
        rst = 1'b1;
        issue(1'b0, 3'b010, 32'h0, 32'h0);
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL rma_first_accept: got %b %h expected 1 00000000", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h1234_5678}) begin failures++; $display("FAIL rma_lw: got %b %h expected 10 12345678", {resp_valid, resp_err}, resp_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_ack = 1'b0;
        checks++; if ({busy, mem_req, resp_valid, req_ready} !== 4'b0001) begin failures++; $display("FAIL b2b_stray: got %b expected 0001", {busy, mem_req, resp_valid, req_ready}); end
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0;
        step();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h20}) begin failures++; $display("FAIL b2b_a_acc: got %b %h expected 1 00000020", mem_req, mem_addr); end
        req_store = 1'b1; req_addr = 32'h24; req_wdata = 32'hCAFE_F00D;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        checks++; if ({resp_valid, resp_rdata, req_ready} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin failures++; $display("FAIL b2b_a_resp: got %b %h %b expected 1 deadbeef 0", resp_valid, resp_rdata, req_ready); end
        step();
        checks++; if ({busy, req_ready, mem_req, resp_valid} !== 4'b0100) begin failures++; $display("FAIL b2b_gap: got %b expected 0100", {busy, req_ready, mem_req, resp_valid}); end
        step();
        req_valid = 1'b0;
        checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {6'b111111, 32'h24, 32'hCAFE_F00D}) begin failures++; $display("FAIL b2b_b_acc: got %b %b %h %h expected 11 1111 00000024 cafef00d", {mem_req, mem_we}, mem_be, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL b2b_b_resp: got %b %h expected 10 00000000", {resp_valid, resp_err}, resp_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_sb_lh();
        test_errors();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
